// File: rtl/proc_core_pkg.sv
// Shared types and field layout for the proc_core_n processor.
// PROC_CORE_MUL_EN selects whether opcode 12 (MUL) has a real multiplier.
package proc_core_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_LSB = 0;

`ifdef PROC_CORE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_MOV  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NOT  = 4'd8,
        OP_SHL  = 4'd9,
        OP_JMP  = 4'd10,
        OP_JZ   = 4'd11,
        OP_MUL  = 4'd12,
        OP_R13  = 4'd13,
        OP_R14  = 4'd14,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Instruction word layout: {op, rd, imm}.
    function automatic int unsigned instr_w(input int unsigned data_w, input int unsigned rw);
        return OP_W + rw + data_w;
    endfunction

endpackage

// File: rtl/proc_core_alu.sv
// Combinational ALU: value and carry for data ops, full-width product for MUL.
// The multiplier exists only when PROC_CORE_MUL_EN is defined.
module proc_core_alu
    import proc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  op_e                 i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [DATA_W-1:0]   i_imm,
    output logic [DATA_W-1:0]   o_value,
    output logic                o_carry,
    output logic [2*DATA_W-1:0] o_product
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [DATA_W:0] w_sum;

`ifdef PROC_CORE_MUL_EN
    assign o_product = PW'(i_a) * PW'(i_b);
`else
    assign o_product = '0;
`endif

    always_comb begin
        w_sum   = '0;
        o_value = i_a;
        o_carry = 1'b0;
        case (i_op)
            OP_LDI: o_value = i_imm;
            OP_MOV: o_value = i_b;
            OP_ADD: begin
                w_sum   = {1'b0, i_a} + {1'b0, i_b};
                o_value = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
            end
            // Borrow appears as the extra top bit of the widened difference.
            OP_SUB: begin
                w_sum   = {1'b0, i_a} - {1'b0, i_b};
                o_value = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
            end
            OP_AND: o_value = i_a & i_b;
            OP_OR:  o_value = i_a | i_b;
            OP_XOR: o_value = i_a ^ i_b;
            OP_NOT: o_value = ~i_a;
            OP_SHL: begin
                o_value = {i_a[DATA_W-2:0], 1'b0};
                o_carry = i_a[DATA_W-1];
            end
            OP_MUL: o_value = o_product[DATA_W-1:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/proc_core_n.sv
// Small accumulator-style processor: 2-cycle FETCH/EXEC, run/step control,
// writable program memory. Define PROC_CORE_MUL_EN to enable the MUL opcode.
module proc_core_n
    import proc_core_pkg::*;
#(
    parameter  int unsigned DATA_W     = 4,
    parameter  int unsigned PROG_DEPTH = 16,
    parameter  int unsigned REGS       = 4,
    localparam int unsigned AW         = $clog2(PROG_DEPTH),
    localparam int unsigned RW         = $clog2(REGS),
    localparam int unsigned INSTR_W    = instr_w(DATA_W, RW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [INSTR_W-1:0]  prog_wdata,
    output logic                prog_ack,
    output logic [AW-1:0]       pc,
    output logic [3:0]          opcode,
    output logic [2*DATA_W-1:0] result,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted,
    input  logic [RW-1:0]       dbg_sel,
    output logic [DATA_W-1:0]   dbg_data
);

    localparam int unsigned PW = 2 * DATA_W;

    state_e               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_step_q;
    logic [DATA_W-1:0]    r_regs [REGS];
    logic [INSTR_W-1:0]   r_mem  [PROG_DEPTH];

    op_e                  w_op;
    logic [RW-1:0]        w_rd;
    logic [RW-1:0]        w_rs;
    logic [DATA_W-1:0]    w_imm;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W-1:0]    w_value;
    logic                 w_carry;
    logic [PW-1:0]        w_product;
    logic [AW-1:0]        w_target;
    logic                 w_step_rise;
    logic                 w_prog_ok;
    logic                 w_is_mul;
    logic                 w_alu_op;
    logic                 w_wr_rd;
    logic                 w_upd_z;

    assign w_op      = op_e'(r_ir[INSTR_W-1 -: OP_W]);
    assign w_rd      = r_ir[IMM_LSB + DATA_W +: RW];
    assign w_imm     = r_ir[IMM_LSB +: DATA_W];
    assign w_rs      = w_imm[RW-1:0];
    assign w_target  = AW'(w_imm);
    assign w_a       = r_regs[w_rd];
    assign w_b       = r_regs[w_rs];
    assign dbg_data  = r_regs[dbg_sel];

    assign w_step_rise = step & ~r_step_q;
    assign w_prog_ok   = prog_we & rst & ((r_state == ST_IDLE) | (r_state == ST_HALT));

    always_comb begin
        w_is_mul = MUL_EN && (w_op == OP_MUL);
        w_alu_op = (w_op >= OP_ADD) && (w_op <= OP_SHL);
        w_wr_rd  = w_alu_op || w_is_mul || (w_op == OP_LDI) || (w_op == OP_MOV);
        w_upd_z  = w_alu_op || w_is_mul;
    end

    proc_core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op      (w_op),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_imm     (w_imm),
        .o_value   (w_value),
        .o_carry   (w_carry),
        .o_product (w_product)
    );

    // Program memory is deliberately outside the reset domain so it survives rst.
    always_ff @(posedge clk) begin
        if (w_prog_ok) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_ir     <= '0;
            r_step_q <= 1'b0;
            pc       <= '0;
            opcode   <= '0;
            result   <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            halted   <= 1'b0;
            prog_ack <= 1'b0;
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_step_q <= step;
            prog_ack <= w_prog_ok;
            case (r_state)
                ST_IDLE: begin
                    if (run || w_step_rise) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= r_mem[pc];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    opcode  <= w_op;
                    pc      <= pc + AW'(1);
                    r_state <= run ? ST_FETCH : ST_IDLE;
                    if (w_wr_rd) begin
                        r_regs[w_rd] <= w_value;
                    end
                    if (w_upd_z) begin
                        flag_z <= (w_value == '0);
                    end
                    if (w_alu_op) begin
                        result <= PW'(w_value);
                    end
                    if (w_is_mul) begin
                        result <= w_product;
                    end
                    case (w_op)
                        OP_ADD, OP_SUB, OP_SHL: flag_c <= w_carry;
                        OP_JMP: pc <= w_target;
                        OP_JZ: begin
                            if (flag_z) begin
                                pc <= w_target;
                            end
                        end
                        OP_HALT: begin
                            halted  <= 1'b1;
                            pc      <= pc;
                            r_state <= ST_HALT;
                        end
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    if (w_step_rise && !run) begin
                        halted  <= 1'b0;
                        pc      <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_core_n.sv
// Self-checking bench for proc_core_n (DATA_W=4, PROG_DEPTH=16, REGS=4).
// Honours PROC_CORE_MUL_EN when choosing MUL expectations.
`timescale 1ns/1ps
module tb_proc_core_n;

    localparam int NV = 13;

    localparam logic [3:0] C_NOP = 4'd0,  C_LDI = 4'd1,  C_MOV = 4'd2,  C_ADD = 4'd3;
    localparam logic [3:0] C_SUB = 4'd4,  C_AND = 4'd5,  C_OR  = 4'd6,  C_XOR = 4'd7;
    localparam logic [3:0] C_NOT = 4'd8,  C_SHL = 4'd9,  C_JMP = 4'd10, C_JZ  = 4'd11;
    localparam logic [3:0] C_MUL = 4'd12, C_R13 = 4'd13, C_HLT = 4'd15;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r0;
        logic       z;
        logic       c;
        logic [7:0] res;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [9:0] prog_wdata = '0;
    logic       prog_ack;
    logic [3:0] pc;
    logic [3:0] opcode;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic [1:0] dbg_sel = '0;
    logic [3:0] dbg_data;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_ack_q[$];
    logic we_seen = 1'b0;
    vec_t vecs[NV];

    proc_core_n #(.DATA_W(4), .PROG_DEPTH(16), .REGS(4)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_ack(prog_ack),
        .pc(pc), .opcode(opcode), .result(result), .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ack scoreboard: one expectation per driven write, compared the cycle after.
    always @(posedge clk) we_seen <= prog_we;
    always @(negedge clk) begin
        if (we_seen) begin
            if (exp_ack_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL prog_ack: got 0x%0h with no expectation queued", prog_ack);
            end else begin
                check("prog_ack", 32'(prog_ack), 32'(exp_ack_q.pop_front()));
            end
        end
    end

    function automatic logic [9:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [3:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic prog_write(input logic [3:0] addr, input logic [9:0] w, input logic exp_ack);
        @(negedge clk);
        prog_addr  = addr;
        prog_wdata = w;
        prog_we    = 1'b1;
        exp_ack_q.push_back(exp_ack);
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        run  = 1'b0;
        step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [3:0] v);
        dbg_sel = idx;
        #1;
        v = dbg_data;
    endtask

    task automatic run_to_halt(input string name);
        int n;
        n   = 0;
        run = 1'b1;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        if (!halted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: halted got 0, expected 1 within 200 cycles", name);
        end
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        logic [3:0] v;

        vecs[0]  = '{C_ADD, 4'd9,  4'd8,  4'd1,  1'b0, 1'b1, 8'h01};
        vecs[1]  = '{C_ADD, 4'd3,  4'd4,  4'd7,  1'b0, 1'b0, 8'h07};
        vecs[2]  = '{C_SUB, 4'd5,  4'd5,  4'd0,  1'b1, 1'b0, 8'h00};
        vecs[3]  = '{C_SUB, 4'd3,  4'd5,  4'd14, 1'b0, 1'b1, 8'h0E};
        vecs[4]  = '{C_AND, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0, 8'h08};
        vecs[5]  = '{C_OR,  4'd12, 4'd3,  4'd15, 1'b0, 1'b0, 8'h0F};
        vecs[6]  = '{C_XOR, 4'd6,  4'd6,  4'd0,  1'b1, 1'b0, 8'h00};
        vecs[7]  = '{C_NOT, 4'd5,  4'd0,  4'd10, 1'b0, 1'b0, 8'h0A};
        vecs[8]  = '{C_SHL, 4'd9,  4'd0,  4'd2,  1'b0, 1'b1, 8'h02};
        vecs[9]  = '{C_SHL, 4'd8,  4'd0,  4'd0,  1'b1, 1'b1, 8'h00};
        vecs[10] = '{C_MOV, 4'd3,  4'd12, 4'd12, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{C_R13, 4'd7,  4'd2,  4'd7,  1'b0, 1'b0, 8'h00};
`ifdef PROC_CORE_MUL_EN
        vecs[12] = '{C_MUL, 4'd15, 4'd15, 4'd1,  1'b0, 1'b0, 8'hE1};
`else
        vecs[12] = '{C_MUL, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 8'h00};
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_result", 32'(result), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_flags", 32'({flag_z, flag_c}), 0);
        check("rst_ack", 32'(prog_ack), 0);
        rst = 1'b1;

        // Table: LDI r0,a; LDI r1,b; OP r0,r1; HALT.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            prog_write(4'd0, mk(C_LDI, 2'd0, vecs[i].a), 1'b1);
            prog_write(4'd1, mk(C_LDI, 2'd1, vecs[i].b), 1'b1);
            prog_write(4'd2, mk(vecs[i].op, 2'd0, 4'd1), 1'b1);
            prog_write(4'd3, mk(C_HLT, 2'd0, 4'd0), 1'b1);
            run_to_halt($sformatf("vec%0d_halt", i));
            read_reg(2'd0, v);
            check($sformatf("vec%0d_r0", i), 32'(v), 32'(vecs[i].r0));
            check($sformatf("vec%0d_z", i), 32'(flag_z), 32'(vecs[i].z));
            check($sformatf("vec%0d_c", i), 32'(flag_c), 32'(vecs[i].c));
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("vec%0d_pc", i), 32'(pc), 3);
            check($sformatf("vec%0d_opcode", i), 32'(opcode), 15);
        end

        // Step out of HALT with run low: back to IDLE at pc 0.
        step_pulse();
        check("unhalt_halted", 32'(halted), 0);
        check("unhalt_pc", 32'(pc), 0);
        repeat (2) @(negedge clk);
        check("unhalt_idle_pc", 32'(pc), 0);

        // SUB to zero then taken JZ over two filler words.
        do_reset();
        prog_write(4'd0, mk(C_LDI, 2'd0, 4'd5), 1'b1);
        prog_write(4'd1, mk(C_LDI, 2'd1, 4'd5), 1'b1);
        prog_write(4'd2, mk(C_SUB, 2'd0, 4'd1), 1'b1);
        prog_write(4'd3, mk(C_JZ,  2'd0, 4'd6), 1'b1);
        prog_write(4'd4, mk(C_LDI, 2'd2, 4'd1), 1'b1);
        prog_write(4'd5, mk(C_LDI, 2'd2, 4'd2), 1'b1);
        prog_write(4'd6, mk(C_HLT, 2'd0, 4'd0), 1'b1);
        run_to_halt("jz_halt");
        read_reg(2'd0, v);
        check("jz_r0", 32'(v), 0);
        read_reg(2'd2, v);
        check("jz_r2_skipped", 32'(v), 0);
        check("jz_z", 32'(flag_z), 1);
        check("jz_c", 32'(flag_c), 0);
        check("jz_pc", 32'(pc), 6);

        // Untaken JZ, JMP, pc wrap 15 -> 0, then taken JZ.
        do_reset();
        prog_write(4'd0,  mk(C_JZ,  2'd0, 4'd8),  1'b1);
        prog_write(4'd1,  mk(C_JMP, 2'd0, 4'd14), 1'b1);
        prog_write(4'd14, mk(C_SUB, 2'd3, 4'd3),  1'b1);
        prog_write(4'd15, mk(C_NOP, 2'd0, 4'd0),  1'b1);
        prog_write(4'd8,  mk(C_HLT, 2'd0, 4'd0),  1'b1);
        run_to_halt("wrap_halt");
        check("wrap_pc", 32'(pc), 8);
        check("wrap_z", 32'(flag_z), 1);

        // Single-step: pc advances once per pulse, then stays idle.
        do_reset();
        for (int a = 0; a < 4; a++) prog_write(4'(a), mk(C_NOP, 2'd0, 4'd0), 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
            check($sformatf("step%0d_pc_before", k), 32'(pc), 32'(k - 1));
            @(negedge clk);
            check($sformatf("step%0d_pc", k), 32'(pc), 32'(k));
            repeat (2) @(negedge clk);
            check($sformatf("step%0d_pc_idle", k), 32'(pc), 32'(k));
        end

        // Asynchronous reset mid-EXEC; program memory must survive.
        do_reset();
        prog_write(4'd0, mk(C_LDI, 2'd0, 4'd9), 1'b1);
        prog_write(4'd1, mk(C_LDI, 2'd1, 4'd8), 1'b1);
        prog_write(4'd2, mk(C_ADD, 2'd0, 4'd1), 1'b1);
        prog_write(4'd3, mk(C_HLT, 2'd0, 4'd0), 1'b1);
        run = 1'b1;
        repeat (4) @(negedge clk);
        dbg_sel = 2'd0;
        #1;
        check("mid_r0_before_rst", 32'(dbg_data), 9);
        check("mid_pc_before_rst", 32'(pc), 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 0);
        check("arst_opcode", 32'(opcode), 0);
        check("arst_result", 32'(result), 0);
        check("arst_flags", 32'({flag_z, flag_c, halted, prog_ack}), 0);
        check("arst_r0", 32'(dbg_data), 0);
        @(negedge clk);
        rst = 1'b1;
        run_to_halt("rerun_halt");
        read_reg(2'd0, v);
        check("rerun_r0", 32'(v), 1);
        check("rerun_result", 32'(result), 1);
        check("rerun_c", 32'(flag_c), 1);
        check("rerun_pc", 32'(pc), 3);

        // Writes while running are dropped; a write in HALT is taken and executes.
        do_reset();
        prog_write(4'd0, mk(C_LDI, 2'd0, 4'd3), 1'b1);
        prog_write(4'd1, mk(C_NOP, 2'd0, 4'd0), 1'b1);
        prog_write(4'd2, mk(C_NOP, 2'd0, 4'd0), 1'b1);
        prog_write(4'd3, mk(C_NOP, 2'd0, 4'd0), 1'b1);
        prog_write(4'd4, mk(C_HLT, 2'd0, 4'd0), 1'b1);
        run = 1'b1;
        prog_write(4'd2, mk(C_LDI, 2'd0, 4'd12), 1'b0);
        prog_write(4'd2, mk(C_LDI, 2'd0, 4'd12), 1'b0);
        run_to_halt("busy_wr_halt");
        read_reg(2'd0, v);
        check("busy_wr_r0", 32'(v), 3);
        check("busy_wr_pc", 32'(pc), 4);
        prog_write(4'd1, mk(C_LDI, 2'd1, 4'd6), 1'b1);
        step_pulse();
        run_to_halt("halt_wr_halt");
        read_reg(2'd1, v);
        check("halt_wr_r1", 32'(v), 6);
        read_reg(2'd0, v);
        check("halt_wr_r0", 32'(v), 3);

        @(negedge clk);
        check("ack_queue_drained", 32'(exp_ack_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_core_n.md
PROC_CORE_N -- requirements
Module: proc_core_n

Interface
REQ-001 SHALL have parameter DATA_W, default 4: datapath and register width, 4..16.
REQ-002 SHALL have parameter PROG_DEPTH, default 16: program memory words, a power of 2; AW = clog2(PROG_DEPTH).
REQ-003 SHALL have parameter REGS, default 4: register count, a power of 2; RW = clog2(REGS); INSTR_W = 4 + RW + DATA_W.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk in 1 rising-edge clock; rst in 1 asynchronous active-low reset.
REQ-005 SHALL have: run in 1, level, free-run enable; step in 1, level, single-step request.
REQ-006 SHALL have: prog_we in 1; prog_addr in AW; prog_wdata in INSTR_W; prog_ack out 1, one-cycle pulse on each accepted write.
REQ-007 SHALL have: pc out AW; opcode out 4, opcode last executed; result out 2*DATA_W, last ALU result; flag_z out 1; flag_c out 1; halted out 1.
REQ-008 SHALL have: dbg_sel in RW; dbg_data out DATA_W, combinational read of register dbg_sel.

Function
REQ-009 Instruction fields SHALL be op = [INSTR_W-1 -: 4], rd = next RW bits, imm = low DATA_W bits; rs = imm[RW-1:0].
REQ-010 FSM states SHALL be IDLE, FETCH, EXEC, HALT; each instruction SHALL take exactly 2 cycles (FETCH registers the word; EXEC does compute, writeback and pc update).
REQ-011 From IDLE: run=1, or a step rising edge detected internally from a registered copy, SHALL enter FETCH; EXEC SHALL go to FETCH if run=1, otherwise to IDLE.
REQ-012 Deasserting run mid-instruction SHALL complete that instruction, then enter IDLE.
REQ-013 Opcodes: 0 NOP; 1 LDI rd=imm; 2 MOV rd=r[rs]; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR (all rd = rd op r[rs]); 8 NOT rd; 9 SHL rd by 1; 10 JMP imm; 11 JZ imm; 12 MUL; 15 HALT; 13 and 14 SHALL execute as NOP.
REQ-014 ADD: flag_c = carry out. SUB: flag_c = borrow. SHL: flag_c = shifted-out MSB. Other ops SHALL leave flag_c unchanged.
REQ-015 flag_z SHALL update only on ops 3-9 and 12, from the DATA_W-bit value written to rd.
REQ-016 result SHALL take the zero-extended written value on ops 3-9 and the full product on MUL; it SHALL hold otherwise.
REQ-017 pc SHALL increment modulo PROG_DEPTH (wrap from PROG_DEPTH-1 to 0); JMP and taken JZ SHALL load imm mod PROG_DEPTH.
REQ-018 HALT SHALL set halted=1, keep pc at the HALT address and enter HALT; in HALT, a step rising edge with run=0 SHALL clear halted, set pc=0 and enter IDLE.
REQ-019 A program write SHALL be accepted only in IDLE or HALT, with prog_ack high the following cycle; in FETCH or EXEC the write SHALL be ignored with no ack.

Reset
REQ-020 rst low SHALL immediately force: state IDLE, pc 0, all registers 0, flags 0, result 0, opcode 0, halted 0, prog_ack 0.
REQ-021 Program memory SHALL NOT be reset; its contents SHALL survive a reset asserted mid-instruction.

Configuration
REQ-022 With macro PROC_CORE_MUL_EN defined, MUL SHALL write the low DATA_W bits of rd*r[rs] to rd and the full 2*DATA_W product to result; undefined, opcode 12 SHALL be a NOP with no multiplier synthesised.

Structure
REQ-023 Package proc_core_pkg SHALL hold the opcode enum, the FSM state enum and the field-position constants.
REQ-024 Sub-module proc_core_alu SHALL be combinational and compute value, carry and product.

Verification (DATA_W=4, REGS=4)
REQ-025 Program LDI r0,9; LDI r1,8; ADD r0,r1; HALT, run=1 -> r0=1, flag_c=1, flag_z=0, result=0x01, halted=1, pc=3 after 8 cycles.
REQ-026 r0=5, r1=5, SUB r0,r1; JZ 6 -> r0=0, flag_z=1, flag_c=0, pc=6.
REQ-027 run=0, three step pulses from pc=0 -> pc goes 1, 2, 3, each 2 cycles after its pulse, then idle.
REQ-028 prog_we during EXEC -> no prog_ack, memory unchanged; prog_we in IDLE -> prog_ack 1 cycle later and the word reads back.
REQ-029 r0=15, r1=15, MUL: with PROC_CORE_MUL_EN -> result=0xE1, r0=1; without -> r0=15, flags unchanged.
REQ-030 rst low mid-EXEC -> all outputs 0 asynchronously; after release, run=1 re-executes the retained program from pc=0.
